// File: rtl/axi_read_addr_queue_pkg.sv
// Shared AXI read-address widths, burst encodings and burst legality helper.
package axi_read_addr_queue_pkg;

  localparam int unsigned ADD_WIDTH    = 32;
  localparam int unsigned ADD_ID_WIDTH = 4;
  localparam int unsigned BURST_LEN    = 4;
  localparam int unsigned BURST_SIZE   = 3;
  localparam int unsigned BURST_TYPE   = 2;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  // WRAP bursts must span 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(logic [BURST_LEN-1:0] len);
    return (len == BURST_LEN'(1)) || (len == BURST_LEN'(3)) ||
           (len == BURST_LEN'(7)) || (len == BURST_LEN'(15));
  endfunction

endpackage

// File: rtl/axi_read_addr_queue_if.sv
// AR channel from the master plus the head-request handshake to the read data stage.
interface axi_read_addr_queue_if
  import axi_read_addr_queue_pkg::*;
#(
  parameter int unsigned ADD_WIDTH    = axi_read_addr_queue_pkg::ADD_WIDTH,
  parameter int unsigned ADD_ID_WIDTH = axi_read_addr_queue_pkg::ADD_ID_WIDTH,
  parameter int unsigned BURST_LEN    = axi_read_addr_queue_pkg::BURST_LEN,
  parameter int unsigned BURST_SIZE   = axi_read_addr_queue_pkg::BURST_SIZE,
  parameter int unsigned BURST_TYPE   = axi_read_addr_queue_pkg::BURST_TYPE
) ();

  logic [ADD_ID_WIDTH-1:0] arid;
  logic [ADD_WIDTH-1:0]    araddr;
  logic [BURST_LEN-1:0]    arlen;
  logic [BURST_SIZE-1:0]   arsize;
  logic [BURST_TYPE-1:0]   arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ADD_WIDTH-1:0]    raddr_out;
  logic [BURST_LEN-1:0]    rlen_out;
  logic [BURST_SIZE-1:0]   rsize_out;
  logic [BURST_TYPE-1:0]   rburst_out;
  logic [ADD_ID_WIDTH-1:0] rid_out;
  logic                    req_valid_out;
  logic                    req_ready_in;

  // Queue side: receives AR beats, sources head requests.
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, req_ready_in,
    output arready, raddr_out, rlen_out, rsize_out, rburst_out, rid_out, req_valid_out
  );

  // Environment side: issues AR beats, consumes head requests.
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, req_ready_in,
    input  arready, raddr_out, rlen_out, rsize_out, rburst_out, rid_out, req_valid_out
  );

endinterface

// File: rtl/axi_read_addr_queue_sync_fifo_ctrl.sv
// FIFO bookkeeping: read/write pointers wrapping modulo DEPTH and an occupancy counter.
module axi_read_addr_queue_sync_fifo_ctrl #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,   // caller guarantees !full
  input  logic            pop,    // caller guarantees !empty
  output logic [PtrW-1:0] wr_ptr,
  output logic [PtrW-1:0] rd_ptr,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
  assign full   = (count_q == CntW'(DEPTH));
  assign empty  = (count_q == '0);

endmodule

// File: rtl/axi_read_addr_queue.sv
// AR channel front end: screens illegal bursts and queues legal ones for the read data stage.
module axi_read_addr_queue
  import axi_read_addr_queue_pkg::*;
#(
  parameter int unsigned ADD_WIDTH    = axi_read_addr_queue_pkg::ADD_WIDTH,
  parameter int unsigned ADD_ID_WIDTH = axi_read_addr_queue_pkg::ADD_ID_WIDTH,
  parameter int unsigned BURST_LEN    = axi_read_addr_queue_pkg::BURST_LEN,
  parameter int unsigned BURST_SIZE   = axi_read_addr_queue_pkg::BURST_SIZE,
  parameter int unsigned BURST_TYPE   = axi_read_addr_queue_pkg::BURST_TYPE,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  axi_read_addr_queue_if.slave     bus,
  output logic                     err_sticky,
  output logic [7:0]               err_count,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic            full, empty;
  logic            ready_q;
  logic            ar_hs, ar_legal, push, pop, illegal;
  logic            err_sticky_q;
  logic [7:0]      err_count_q;

  logic [ADD_WIDTH-1:0]    addr_mem  [DEPTH];
  logic [BURST_LEN-1:0]    len_mem   [DEPTH];
  logic [BURST_SIZE-1:0]   size_mem  [DEPTH];
  logic [BURST_TYPE-1:0]   burst_mem [DEPTH];
  logic [ADD_ID_WIDTH-1:0] id_mem    [DEPTH];

  // Holds arready low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // Full blocks new beats even when a pop is happening this cycle.
  assign bus.arready = ready_q & ~full;
  assign ar_hs       = bus.arvalid & bus.arready;

  // Burst legality screen; arsize is not checked against the data width here.
  always_comb begin
    ar_legal = 1'b1;
    if (bus.arburst == BURST_RSVD) ar_legal = 1'b0;
    if ((bus.arburst == BURST_WRAP) && !wrap_len_ok(bus.arlen)) ar_legal = 1'b0;
  end

  assign push    = ar_hs & ar_legal;
  assign illegal = ar_hs & ~ar_legal;
  assign pop     = bus.req_valid_out & bus.req_ready_in;

  axi_read_addr_queue_sync_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_fifo_ctrl (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (occupancy),
    .full   (full),
    .empty  (empty)
  );

  // Request storage; cleared on reset so head fields never read X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i]  <= '0;
        len_mem[i]   <= '0;
        size_mem[i]  <= '0;
        burst_mem[i] <= '0;
        id_mem[i]    <= '0;
      end
    end else if (push) begin
      addr_mem[wr_ptr]  <= bus.araddr;
      len_mem[wr_ptr]   <= bus.arlen;
      size_mem[wr_ptr]  <= bus.arsize;
      burst_mem[wr_ptr] <= bus.arburst;
      id_mem[wr_ptr]    <= bus.arid;
    end
  end

  // Error flag and saturating illegal-AR counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else if (illegal) begin
      err_sticky_q <= 1'b1;
      if (err_count_q != 8'hff) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

  assign bus.req_valid_out = ~empty;
  assign bus.raddr_out     = addr_mem[rd_ptr];
  assign bus.rlen_out      = len_mem[rd_ptr];
  assign bus.rsize_out     = size_mem[rd_ptr];
  assign bus.rburst_out    = burst_mem[rd_ptr];
  assign bus.rid_out       = id_mem[rd_ptr];

endmodule

// File: doc/axi_read_addr_queue.md
Name: axi_read_addr_queue

Overview:
- AXI read-address (AR) channel front end of the memory slave.
- Accepts AR beats from the master and screens out illegal bursts.
- Buffers legal requests in a DEPTH-entry FIFO and presents the head request, with a valid/ready handshake, to the read data stage (raddr_in/rlen_in/rsize_in/rburst_in/rid_in, read_mod1_valid_in/read_mod1_ready_out).
- Decouples master AR issue from read-burst completion so several reads can be outstanding.

Parameters:
ADD_WIDTH, 32, address width
ADD_ID_WIDTH, 4, transaction ID width
BURST_LEN, 4, arlen width (beats = arlen+1)
BURST_SIZE, 3, arsize width (bytes per beat = 2**arsize)
BURST_TYPE, 2, arburst width
DEPTH, 4, FIFO entries; power of two, >=2

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
arid  in  ADD_ID_WIDTH  AR ID
araddr  in  ADD_WIDTH  AR start address
arlen  in  BURST_LEN  AR burst length
arsize  in  BURST_SIZE  AR beat size
arburst  in  BURST_TYPE  AR burst type (00 FIXED, 01 INCR, 10 WRAP, 11 reserved)
arvalid  in  1  AR valid
arready  out  1  AR ready
raddr_out  out  ADD_WIDTH  head address to read data stage
rlen_out  out  BURST_LEN  head length
rsize_out  out  BURST_SIZE  head size
rburst_out  out  BURST_TYPE  head burst type
rid_out  out  ADD_ID_WIDTH  head ID
req_valid_out  out  1  head entry valid (to read_mod1_valid_in)
req_ready_in  in  1  downstream ready (from read_mod1_ready_out)
err_sticky  out  1  an illegal AR was seen since reset
err_count  out  8  illegal-AR count, saturating at 255
occupancy  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=rd_ptr=0, occupancy=0, req_valid_out=0, err_sticky=0, err_count=0, all head fields 0. arready=0 while reset is asserted, and 1 from the first clock edge after release.
- arready = (occupancy < DEPTH). Registered from state; no combinational path from req_ready_in. When full, there is no same-cycle pass-through even if a pop occurs.
- Push: arvalid && arready at an edge.
- Legality check, applied at push:
  - arburst==11 is illegal.
  - WRAP with arlen not in {1,3,7,15} is illegal.
  - arsize > log2(DATA bytes) is not checked here.
- A legal AR is written to mem[wr_ptr] and wr_ptr increments.
- An illegal AR is still handshaken (arready honoured) but dropped: no write; err_sticky <= 1; err_count increments, saturating at 255.
- Pop: req_valid_out && req_ready_in at an edge; rd_ptr increments.
- Head outputs are driven combinationally from mem[rd_ptr]. req_valid_out = (occupancy != 0).
- Latency: a legal AR accepted at edge N gives req_valid_out=1 after edge N, with its fields visible in that same cycle. Minimum AR-to-downstream latency is 1 cycle.
- Simultaneous legal push and pop: occupancy unchanged, both pointers advance. When empty, a push plus req_ready_in=1 does not pop the new entry in that cycle.
- Simultaneous illegal push and pop: occupancy decrements.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is kept as a separate counter; full/empty derive from it.
- Head fields are stable while req_valid_out=1 and req_ready_in=0 (AXI-style hold).
- Order is preserved strictly FIFO; there is no ID-based reordering.
- Reset asserted mid-operation discards all queued entries immediately. The downstream stage must be reset concurrently.
- No X propagation: with occupancy=0, head fields read whatever is in the entry at rd_ptr (don't-care), and req_valid_out=0.

Decomposition:
- Shared package/header: AXI width constants (ADD_WIDTH, ADD_ID_WIDTH, BURST_LEN, BURST_SIZE, BURST_TYPE) and the burst-type encodings BURST_FIXED=0, BURST_INCR=1, BURST_WRAP=2, BURST_RSVD=3.
- One natural sub-module: sync_fifo_ctrl, covering pointers, occupancy and full/empty, parameterised by DEPTH. Storage array and legality check stay in the top level.

Test Plan:
1. Single AR: arid=3, araddr=0x1000, arlen=7, arsize=2, arburst=01, req_ready_in=0 -> next cycle req_valid_out=1 with fields matching; fields held for 5 cycles; req_ready_in=1 pops, and req_valid_out=0 in the following cycle.
2. Fill: 4 legal ARs back-to-back, req_ready_in=0 -> occupancy=4, arready=0; a 5th arvalid is held off. One pop -> arready=1 next cycle and the 5th is accepted. Order out is IDs 0,1,2,3,4.
3. Streaming: arvalid=1 and req_ready_in=1 continuously for 20 ARs -> occupancy stays at 1 after the first beat; all 20 IDs emerge in order; pointers wrap 5 times.
4. Illegal: arburst=11, then WRAP with arlen=5 -> both handshaken; neither is queued; err_sticky=1; err_count=2; occupancy unchanged.
5. Reset mid-operation: 3 entries queued, pulse reset=0 between edges -> occupancy=0, req_valid_out=0, err_sticky=0 immediately (asynchronous). After release, a new AR flows normally.
